// File: rtl/batch_denorm_if.sv
// rtl/batch_denorm_if.sv - operand/result handshake bundle for batch_denorm
interface batch_denorm_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_denorm_data;
  logic [DATA_WIDTH-1:0] i_denorm_weight;
  logic [DATA_WIDTH-1:0] i_denorm_bias;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_denorm_data;
  logic                  o_denorm_overflow;
  logic                  o_denorm_div_zero;

  modport slave (
    input  i_valid, i_denorm_data, i_denorm_weight, i_denorm_bias, i_ready,
    output o_ready, o_valid, o_denorm_data, o_denorm_overflow, o_denorm_div_zero
  );

  modport master (
    output i_valid, i_denorm_data, i_denorm_weight, i_denorm_bias, i_ready,
    input  o_ready, o_valid, o_denorm_data, o_denorm_overflow, o_denorm_div_zero
  );
endinterface

// File: rtl/batch_denorm.sv
// rtl/batch_denorm.sv - x = (y - b) / w in signed-magnitude Q format, restoring divider
module batch_denorm #(
  parameter int DATA_WIDTH     = 32,
  parameter int FRACTION_WIDTH = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  batch_denorm_if.slave  bus
);
  localparam int MW = DATA_WIDTH - 1;
  localparam int QW = MW + FRACTION_WIDTH;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DIV, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_y, r_w, r_b;
  logic [QW-1:0]         r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [CW-1:0]         r_cnt;
  logic                  r_sign, r_ovf;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_ovf, r_out_dz;

  logic                  w_ready, w_accept;
  logic [MW-1:0]         w_my, w_mb, w_mw;
  logic                  w_sy, w_snb, w_sw_eff, w_w_zero;
  logic [MW:0]           w_d_mag;
  logic                  w_d_sign, w_d_sign_eff, w_res_sign, w_d_sat;
  logic [MW-1:0]         w_d_mag_sat;
  logic [DATA_WIDTH-1:0] w_trial, w_divisor;
  logic                  w_ge, w_last, w_div_ovf;
  logic [QW-1:0]         w_q_final;
  logic [MW-1:0]         w_q_mag;

  assign w_ready  = (r_state == S_IDLE) & i_rst_n;
  assign w_accept = w_ready & bus.i_valid;

  assign w_my     = r_y[MW-1:0];
  assign w_mb     = r_b[MW-1:0];
  assign w_mw     = r_w[MW-1:0];
  assign w_sy     = r_y[DATA_WIDTH-1];
  assign w_snb    = ~r_b[DATA_WIDTH-1];
  assign w_w_zero = (w_mw == '0);
  assign w_sw_eff = r_w[DATA_WIDTH-1] & ~w_w_zero;

  // y - b evaluated as y + (-b) with qadd sign-magnitude rules
  always_comb begin
    w_d_mag  = '0;
    w_d_sign = 1'b0;
    if (w_sy == w_snb) begin
      w_d_mag  = {1'b0, w_my} + {1'b0, w_mb};
      w_d_sign = w_sy;
    end else if (w_my >= w_mb) begin
      w_d_mag  = {1'b0, w_my - w_mb};
      w_d_sign = w_sy;
    end else begin
      w_d_mag  = {1'b0, w_mb - w_my};
      w_d_sign = w_snb;
    end
  end

  assign w_d_sat      = w_d_mag[MW];
  assign w_d_mag_sat  = w_d_sat ? {MW{1'b1}} : w_d_mag[MW-1:0];
  assign w_d_sign_eff = w_d_sign & (w_d_mag != '0);
  assign w_res_sign   = w_d_sign_eff ^ w_sw_eff;

  // The quotient shifts into r_quo from the bottom as dividend bits leave the top
  assign w_divisor = {1'b0, w_mw};
  assign w_trial   = (r_rem << 1) | DATA_WIDTH'(r_quo[QW-1]);
  assign w_ge      = (w_trial >= w_divisor);
  assign w_last    = (r_cnt == CW'(QW - 1));
  assign w_q_final = {r_quo[QW-2:0], w_ge};
  assign w_div_ovf = |w_q_final[QW-1:MW];
  assign w_q_mag   = w_div_ovf ? {MW{1'b1}} : w_q_final[MW-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_SUB;
      S_SUB:  w_next = w_w_zero ? S_DONE : S_DIV;
      S_DIV:  if (w_last) w_next = S_DONE;
      S_DONE: if (bus.i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_y        <= '0;
      r_w        <= '0;
      r_b        <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_out_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_y       <= bus.i_denorm_data;
          r_w       <= bus.i_denorm_weight;
          r_b       <= bus.i_denorm_bias;
          r_out_ovf <= 1'b0;
          r_out_dz  <= 1'b0;
        end
        S_SUB: begin
          r_sign <= w_res_sign;
          r_ovf  <= w_d_sat;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_quo  <= {w_d_mag_sat, {FRACTION_WIDTH{1'b0}}};
          if (w_w_zero) begin
            r_out_data <= {w_res_sign, {MW{1'b1}}};
            r_out_ovf  <= 1'b1;
            r_out_dz   <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? (w_trial - w_divisor) : w_trial;
          r_quo <= w_q_final;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_data <= {r_sign & (w_q_mag != '0), w_q_mag};
            r_out_ovf  <= r_ovf | w_div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready           = w_ready;
  assign bus.o_valid           = (r_state == S_DONE);
  assign bus.o_denorm_data     = r_out_data;
  assign bus.o_denorm_overflow = r_out_ovf;
  assign bus.o_denorm_div_zero = r_out_dz;
endmodule

// File: tb/tb_batch_denorm.sv
// tb/tb_batch_denorm.sv - directed self-checking bench for batch_denorm
module tb_batch_denorm;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  batch_denorm_if #(.DATA_WIDTH(32)) bus ();

  batch_denorm #(.DATA_WIDTH(32), .FRACTION_WIDTH(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] y, input logic [31:0] b, input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_valid         = 1'b1;
    bus.i_denorm_data   = y;
    bus.i_denorm_bias   = b;
    bus.i_denorm_weight = w;
    while (bus.o_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", {31'b0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] y, input logic [31:0] b,
                     input logic [31:0] w, input logic [31:0] exp_d, input logic exp_o,
                     input logic exp_z, input int exp_lat);
    int n;
    send(y, b, w);
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n + 1), 32'(exp_lat));
    check({tag, "_data"}, bus.o_denorm_data, exp_d);
    check({tag, "_ovf"}, {31'b0, bus.o_denorm_overflow}, {31'b0, exp_o});
    check({tag, "_dz"}, {31'b0, bus.o_denorm_div_zero}, {31'b0, exp_z});
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, "_ready_after_ack"}, {31'b0, bus.o_ready}, 32'd1);
    check({tag, "_valid_after_ack"}, {31'b0, bus.o_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.i_valid         = 1'b0;
    bus.i_ready         = 1'b0;
    bus.i_denorm_data   = '0;
    bus.i_denorm_bias   = '0;
    bus.i_denorm_weight = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
    check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    check("rst_data", bus.o_denorm_data, 32'h0);
    check("rst_ovf", {31'b0, bus.o_denorm_overflow}, 32'd0);
    check("rst_dz", {31'b0, bus.o_denorm_div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'b0, bus.o_ready}, 32'd1);

    run("basic", 32'h00018000, 32'h00008000, 32'h00010000, 32'h00008000, 1'b0, 1'b0, 48);
    ack("basic");
    run("neg_y", 32'h80008000, 32'h00008000, 32'h00010000, 32'h80008000, 1'b0, 1'b0, 48);
    ack("neg_y");
    run("neg_yw", 32'h80008000, 32'h00008000, 32'h80010000, 32'h00008000, 1'b0, 1'b0, 48);
    ack("neg_yw");
    run("div_ovf", 32'h7FFF0000, 32'h00000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 48);
    ack("div_ovf");
    run("sub_sat", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b1, 1'b0, 48);
    ack("sub_sat");
    run("zero", 32'h00008000, 32'h00008000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 48);
    ack("zero");
    run("neg_zero", 32'h80000000, 32'h00000000, 32'h80008000, 32'h00000000, 1'b0, 1'b0, 48);
    ack("neg_zero");
    run("trunc_pos", 32'h00008000, 32'h00000000, 32'h00018000, 32'h00002AAA, 1'b0, 1'b0, 48);
    ack("trunc_pos");
    run("trunc_neg", 32'h80008000, 32'h00000000, 32'h00018000, 32'h80002AAA, 1'b0, 1'b0, 48);
    ack("trunc_neg");

    // Divide-by-zero result held with i_ready low while new operands are offered
    run("div_zero", 32'h00018000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_valid         = (i < 5);
      bus.i_denorm_data   = 32'h00004000 + 32'(i);
      bus.i_denorm_weight = 32'h00008000;
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, bus.o_valid}, 32'd1);
      check("hold_ready", {31'b0, bus.o_ready}, 32'd0);
      check("hold_data", bus.o_denorm_data, 32'h7FFFFFFF);
    end
    check("hold_ovf", {31'b0, bus.o_denorm_overflow}, 32'd1);
    check("hold_dz", {31'b0, bus.o_denorm_div_zero}, 32'd1);
    ack("hold");

    // Flags from the previous result clear on the next accept
    run("after_dz", 32'h00018000, 32'h00008000, 32'h00010000, 32'h00008000, 1'b0, 1'b0, 48);
    ack("after_dz");

    // Reset during DIV cycle 20 aborts the operation
    send(32'h00018000, 32'h00008000, 32'h00010000);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_in_rst", {31'b0, bus.o_ready}, 32'd0);
    check("abort_valid_in_rst", {31'b0, bus.o_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_after", {31'b0, bus.o_ready}, 32'd1);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_valid", {31'b0, seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
